// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready handshake block family.
//   occ_width(stages) : bit width needed to count 0..2*stages buffered beats
//                       in a chain of 2-entry skid stages.
package handshake_pkg;

  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/handshake_skid_stage.sv
// One 2-entry skid-buffer stage. Registers both the forward path
// (valid/data) and the backward path (ready), at full throughput.
//   clk, rst_n           : clock, async active-low reset
//   flush                : synchronous clear of both entries (data kept)
//   in_valid/in_data     : upstream beat
//   in_ready             : NOT skid_valid (flop-driven)
//   out_valid/out_data   : main register contents
//   out_ready            : downstream accepts
module skid_stage #(
  parameter int DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, take;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign acc  = in_valid & ~skid_valid;
  assign take = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (take && skid_valid) begin
      // skid refills main; acc cannot occur since in_ready is low
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end else if (acc && (!main_valid || take)) begin
      main_data  <= in_data;
      main_valid <= 1'b1;
    end else if (acc) begin
      // main stalled: park the in-flight beat in the skid entry
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end else if (take) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/handshake_skid_pipe.sv
// Valid/ready pipeline of STAGES cascaded 2-entry skid stages. Both the
// forward and backward handshake paths are registered at every stage, so
// no input reaches an output combinationally. Capacity is 2*STAGES beats.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous clear of all held beats and occupancy
//   in_valid/in_data    : upstream beat;  in_ready: stage-0 can accept
//   out_valid/out_data  : last-stage beat; out_ready: downstream accepts
//   occupancy           : registered count of beats held (0..2*STAGES)
module handshake_skid_pipe
  import handshake_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int STAGES = 2,
  localparam int CNT_W  = occ_width(STAGES)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  occupancy
);

  // Link k is the input of stage k; link STAGES is the pipe output.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             rdy_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;

  assign vld_pipe[0]      = in_valid;
  assign dat_pipe[0]      = in_data;
  assign in_ready         = rdy_pipe[0];
  assign out_valid        = vld_pipe[STAGES];
  assign out_data         = dat_pipe[STAGES];
  assign rdy_pipe[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      skid_stage #(.DATA_W(DATA_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (vld_pipe[k]),
        .in_data   (dat_pipe[k]),
        .in_ready  (rdy_pipe[k]),
        .out_valid (vld_pipe[k+1]),
        .out_data  (dat_pipe[k+1]),
        .out_ready (rdy_pipe[k+1])
      );
    end
  endgenerate

  logic in_fire, out_fire;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occupancy <= '0;
    else if (flush)
      occupancy <= '0;
    else if (in_fire && !out_fire)
      occupancy <= occupancy + CNT_W'(1);
    else if (out_fire && !in_fire)
      occupancy <= occupancy - CNT_W'(1);
  end

endmodule
